// File: rtl/mem_sp_stream_reader.sv
// Read sequencer for the single-ported coefficient RAM: issues LEN wrapped reads
// from BASE and streams the words out through a 2-entry first-word-fall-through skid FIFO.
module mem_sp_stream_reader #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 64,
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AW-1:0]    base,
    input  logic [AW:0]      len,
    output logic             busy,
    output logic             done,
    output logic             mem_en,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    input  logic [WIDTH-1:0] mem_do,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [AW-1:0]    addr, addr_nx;
    logic [AW:0]      remaining, remaining_nx;
    logic [AW:0]      sent, sent_nx;
    logic [AW:0]      len_q, len_nx;
    logic             inflight;
    logic             issue;
    logic             push;
    logic             pop;
    logic [2:0]       occ;

    logic [WIDTH-1:0] fifo_mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       fifo_count;

    // Modulo-DEPTH increment, correct for non-power-of-two depths
    function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
        if (a == AW'(DEPTH - 1)) begin
            return '0;
        end
        return a + AW'(1);
    endfunction

    assign pop       = out_valid && out_ready;
    assign push      = inflight;
    assign occ       = 3'(fifo_count) + 3'(inflight);
    assign out_valid = (fifo_count != 2'd0);
    assign out_data  = fifo_mem[rd_ptr];
    assign mem_en    = issue;
    assign mem_we    = 1'b0;
    assign mem_addr  = addr;
    assign busy      = (state != IDLE);
    assign done      = (state == FIN);

    // State and transfer bookkeeping registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            sent      <= '0;
            len_q     <= '0;
            inflight  <= 1'b0;
        end else begin
            state     <= state_nx;
            addr      <= addr_nx;
            remaining <= remaining_nx;
            sent      <= sent_nx;
            len_q     <= len_nx;
            inflight  <= issue;
        end
    end

    // Next-state logic; a read goes out only if it still fits after this cycle's pop
    always_comb begin
        state_nx     = state;
        addr_nx      = addr;
        remaining_nx = remaining;
        sent_nx      = sent;
        len_nx       = len_q;
        issue        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    addr_nx      = base;
                    remaining_nx = len;
                    len_nx       = len;
                    sent_nx      = '0;
                    state_nx     = (len == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                if ((remaining != '0) && ((occ - 3'(pop)) < 3'd2)) begin
                    issue        = 1'b1;
                    remaining_nx = remaining - (AW+1)'(1);
                    addr_nx      = addr_inc(addr);
                end
                if (pop) begin
                    sent_nx = sent + (AW+1)'(1);
                    if ((sent + (AW+1)'(1)) == len_q) begin
                        state_nx = FIN;
                    end
                end
            end
            FIN: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Skid FIFO: RAM word captured the cycle after its read was issued
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_count  <= 2'd0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= mem_do;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    a_no_write: assert property (@(posedge clk) disable iff (rst) !mem_we);
    a_no_read_idle: assert property (@(posedge clk) disable iff (rst) !(mem_en && (state == IDLE)));
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && (fifo_count == 2'd2)));

endmodule
